feature_bram_writer: RTL and testbench

//   Producer end of the feature BRAM feeding the modulation classifier.

---
 rtl/feature_pkg.sv | 43 ++++
 rtl/abs_accum.sv | 49 ++++
 rtl/feature_bram_writer.sv | 197 +++++++++++++++++++
 tb/tb_feature_bram_writer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_pkg.sv
// -----------------------------------------------------------------------------
// feature_pkg
//   Shared definitions for the feature BRAM producer (feature_bram_writer) and
//   the classifier that reads the same BRAM region.
//   - state_t        : writer FSM states
//   - FEAT_W/WORD_W/ADDR_W : sample, BRAM word and BRAM address widths
//   - OFF_AP/AF/DP   : word offsets of each feature inside a frame record
//   - sat_abs()      : saturating absolute value of a signed feature sample
// -----------------------------------------------------------------------------
package feature_pkg;

    localparam int unsigned FEAT_W          = 16;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned ADDR_W          = 16;

    // Layout of one frame record in BRAM; the classifier uses the same offsets.
    localparam int unsigned OFF_AP          = 0;
    localparam int unsigned OFF_AF          = 1;
    localparam int unsigned OFF_DP          = 2;
    localparam int unsigned WORDS_PER_FRAME = 3;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_WR_AP = 2'd1,
        ST_WR_AF = 2'd2,
        ST_WR_DP = 2'd3
    } state_t;

    // |x| with the most negative code mapped to the most positive one, so the
    // result always fits in FEAT_W bits.
    function automatic logic [FEAT_W-1:0] sat_abs(input logic signed [FEAT_W-1:0] x);
        logic [FEAT_W-1:0] r;
        if (x == {1'b1, {(FEAT_W-1){1'b0}}}) begin
            r = {1'b0, {(FEAT_W-1){1'b1}}};
        end else if (x[FEAT_W-1]) begin
            r = -x;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/abs_accum.sv
// -----------------------------------------------------------------------------
// abs_accum
//   Accumulates the saturating absolute value of a signed feature sample into
//   a WORD_W-bit sum.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (clears the sum)
//     clr        : synchronous clear (takes priority over en)
//     en         : add |x| this cycle
//     x          : signed sample
//     acc_nxt    : value the sum takes at the next edge (clear / add / hold
//                  already applied); lets the owner latch a final sum in the
//                  same cycle the last sample is added
// -----------------------------------------------------------------------------
module abs_accum
    import feature_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [FEAT_W-1:0] x,
    output logic [WORD_W-1:0]        acc_nxt
);

    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_d;
    logic [FEAT_W-1:0] abs_x;

    always_comb begin
        abs_x = sat_abs(x);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + {{(WORD_W-FEAT_W){1'b0}}, abs_x};
        end
    end

    assign acc_nxt = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/feature_bram_writer.sv
// -----------------------------------------------------------------------------
// feature_bram_writer
//   Producer end of the feature BRAM. Averages |ap|, |af|, |dp| over frames of
//   2**LOG2_N samples and writes each frame as three consecutive words
//   (sigma_ap, sigma_af, sigma_dp) into a ring of NUM_FRAMES records starting
//   at BASE_ADDR.
//   Parameters:
//     LOG2_N     : log2 of samples per frame (1..16)
//     BASE_ADDR  : word address of frame 0's sigma_ap
//     NUM_FRAMES : frame slots in the ring (ring is 3*NUM_FRAMES words)
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     s_valid / s_ready   : sample handshake (accept when both high)
//     s_ap, s_af, s_dp    : signed instantaneous deviations
//     bram_en, bram_we    : BRAM port enable / write enable
//     bram_addr, bram_din : BRAM word address / write data
//     frame_done          : one-cycle pulse with the sigma_dp write
//     frame_count         : frames completed since reset (wraps)
//   All outputs are registered.
// -----------------------------------------------------------------------------
module feature_bram_writer
    import feature_pkg::*;
#(
    parameter int unsigned       LOG2_N     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'd0,
    parameter int unsigned       NUM_FRAMES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [FEAT_W-1:0] s_ap,
    input  logic signed [FEAT_W-1:0] s_af,
    input  logic signed [FEAT_W-1:0] s_dp,
    output logic                     bram_en,
    output logic                     bram_we,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic [WORD_W-1:0]        bram_din,
    output logic                     frame_done,
    output logic [15:0]              frame_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR =
        ADDR_W'(BASE_ADDR + WORDS_PER_FRAME * NUM_FRAMES - 1);

    state_t              state_q,       state_d;
    logic [LOG2_N-1:0]   cnt_q,         cnt_d;
    logic [ADDR_W-1:0]   wr_ptr_q,      wr_ptr_d;
    logic                s_ready_q,     s_ready_d;
    logic                bram_en_q,     bram_en_d;
    logic                bram_we_q,     bram_we_d;
    logic [ADDR_W-1:0]   bram_addr_q,   bram_addr_d;
    logic [WORD_W-1:0]   bram_din_q,    bram_din_d;
    logic                frame_done_q,  frame_done_d;
    logic [15:0]         frame_count_q, frame_count_d;

    logic                accept;
    logic                acc_en;
    logic                acc_clr;
    logic [WORD_W-1:0]   nxt_ap;
    logic [WORD_W-1:0]   nxt_af;
    logic [WORD_W-1:0]   nxt_dp;
    logic [ADDR_W-1:0]   wr_ptr_inc;

    assign accept = s_valid && s_ready_q && (state_q == ST_ACCUM);

    abs_accum u_acc_ap (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .en      (acc_en),
        .x       (s_ap),
        .acc_nxt (nxt_ap)
    );

    abs_accum u_acc_af (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .en      (acc_en),
        .x       (s_af),
        .acc_nxt (nxt_af)
    );

    abs_accum u_acc_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .en      (acc_en),
        .x       (s_dp),
        .acc_nxt (nxt_dp)
    );

    always_comb begin
        wr_ptr_inc = (wr_ptr_q == LAST_ADDR) ? BASE_ADDR : (wr_ptr_q + 16'd1);
    end

    // The sigma_ap word is registered on the same edge that accepts the last
    // sample, so it is taken from the accumulator's next value (which already
    // includes that sample). sigma_af / sigma_dp are read one and two cycles
    // later, when their accumulators are idle and nxt equals the held sum.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wr_ptr_d      = wr_ptr_q;
        s_ready_d     = s_ready_q;
        bram_en_d     = 1'b0;
        bram_we_d     = 1'b0;
        bram_addr_d   = bram_addr_q;
        bram_din_d    = bram_din_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        acc_en        = 1'b0;
        acc_clr       = 1'b0;

        unique case (state_q)
            ST_ACCUM: begin
                s_ready_d = 1'b1;
                if (accept) begin
                    acc_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d     = ST_WR_AP;
                        s_ready_d   = 1'b0;
                        bram_en_d   = 1'b1;
                        bram_we_d   = 1'b1;
                        bram_addr_d = wr_ptr_q;
                        bram_din_d  = nxt_ap >> LOG2_N;
                        wr_ptr_d    = wr_ptr_inc;
                    end
                end
            end
            ST_WR_AP: begin
                state_d     = ST_WR_AF;
                bram_en_d   = 1'b1;
                bram_we_d   = 1'b1;
                bram_addr_d = wr_ptr_q;
                bram_din_d  = nxt_af >> LOG2_N;
                wr_ptr_d    = wr_ptr_inc;
            end
            ST_WR_AF: begin
                state_d       = ST_WR_DP;
                bram_en_d     = 1'b1;
                bram_we_d     = 1'b1;
                bram_addr_d   = wr_ptr_q;
                bram_din_d    = nxt_dp >> LOG2_N;
                wr_ptr_d      = wr_ptr_inc;
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
            end
            ST_WR_DP: begin
                state_d   = ST_ACCUM;
                s_ready_d = 1'b1;
                acc_clr   = 1'b1;
                cnt_d     = '0;
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ACCUM;
            cnt_q         <= '0;
            wr_ptr_q      <= BASE_ADDR;
            s_ready_q     <= 1'b0;
            bram_en_q     <= 1'b0;
            bram_we_q     <= 1'b0;
            bram_addr_q   <= BASE_ADDR;
            bram_din_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            s_ready_q     <= s_ready_d;
            bram_en_q     <= bram_en_d;
            bram_we_q     <= bram_we_d;
            bram_addr_q   <= bram_addr_d;
            bram_din_q    <= bram_din_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign bram_en     = bram_en_q;
    assign bram_we     = bram_we_q;
    assign bram_addr   = bram_addr_q;
    assign bram_din    = bram_din_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_feature_bram_writer.sv
module tb_feature_bram_writer;

    localparam int unsigned L2N = 2;
    localparam int unsigned NS  = 1 << L2N;
    localparam int unsigned NFR = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: 4 samples/frame, 2-frame ring at address 0
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_ap, s_af, s_dp;
    logic        bram_en, bram_we;
    logic [15:0] bram_addr;
    logic [31:0] bram_din;
    logic        frame_done;
    logic [15:0] frame_count;

    feature_bram_writer #(.LOG2_N(L2N), .BASE_ADDR(16'd0), .NUM_FRAMES(NFR)) u_dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_ap(s_ap), .s_af(s_af), .s_dp(s_dp),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    // large instance: 65536 samples/frame, ring at address 100
    logic        rst16_n;
    logic        v16;
    logic        r16;
    logic [15:0] ap16, af16, dp16;
    logic        en16, we16;
    logic [15:0] addr16;
    logic [31:0] din16;
    logic        fd16;
    logic [15:0] fc16;

    feature_bram_writer #(.LOG2_N(16), .BASE_ADDR(16'd100), .NUM_FRAMES(4)) u_dut16 (
        .clk(clk), .rst_n(rst16_n), .s_valid(v16), .s_ready(r16),
        .s_ap(ap16), .s_af(af16), .s_dp(dp16),
        .bram_en(en16), .bram_we(we16), .bram_addr(addr16), .bram_din(din16),
        .frame_done(fd16), .frame_count(fc16)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic [1:0]  idx;
        logic [15:0] fcount;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] m_ptr;
    logic [15:0] m_fcount;
    logic [31:0] m_sum[3];
    int unsigned m_cnt;

    function automatic logic [31:0] mabs(input logic [15:0] v);
        int iv;
        iv = int'($signed(v));
        if (iv < -32767) iv = -32767;
        if (iv < 0) iv = -iv;
        return 32'(iv);
    endfunction

    task automatic model_reset();
        m_ptr    = 16'd0;
        m_fcount = 16'd0;
        m_cnt    = 0;
        for (int k = 0; k < 3; k++) m_sum[k] = 32'd0;
    endtask

    task automatic model_accept(input logic [15:0] ap, input logic [15:0] af, input logic [15:0] dp);
        wr_t e;
        m_sum[0] += mabs(ap);
        m_sum[1] += mabs(af);
        m_sum[2] += mabs(dp);
        m_cnt++;
        if (m_cnt == NS) begin
            m_fcount = m_fcount + 16'd1;
            for (int k = 0; k < 3; k++) begin
                e.addr   = m_ptr;
                e.data   = m_sum[k] >> L2N;
                e.idx    = 2'(k);
                e.fcount = m_fcount;
                exp_q.push_back(e);
                m_ptr = (m_ptr == 16'(3 * NFR - 1)) ? 16'd0 : m_ptr + 16'd1;
                m_sum[k] = 32'd0;
            end
            m_cnt = 0;
        end
    endtask

    // ---------------- monitor ----------------
    int unsigned cyc = 0;
    int unsigned last_acc = 0;
    bit          exp_ready_next = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (exp_ready_next) begin
                check("ready_back_t+4", s_ready, 1);
                exp_ready_next = 0;
            end
            if (bram_en) begin
                check("bram_we", bram_we, 1);
                check("ready_low_in_write", s_ready, 0);
                if (exp_q.size() == 0) begin
                    check("spurious_write_pending", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("addr", bram_addr, e.addr);
                    check("din", bram_din, e.data);
                    check("frame_done", frame_done, e.idx == 2'd2);
                    check("write_latency", cyc - last_acc, e.idx);
                    if (e.idx == 2'd2) begin
                        check("frame_count", frame_count, e.fcount);
                        exp_ready_next = 1;
                    end
                end
            end else begin
                check("idle_we", bram_we, 0);
                check("idle_done", frame_done, 0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [15:0] ap, input logic [15:0] af, input logic [15:0] dp,
                        input bit gap);
        int unsigned w = 0;
        bit          took = 0;
        s_valid = 1'b1;
        s_ap = ap; s_af = af; s_dp = dp;
        while (!took) begin
            @(negedge clk);
            took = s_ready;
            @(posedge clk);
            #1;
            if (!took) begin
                w++;
                if (w > 10) begin
                    check("accept_timeout", w, 0);
                    return;
                end
            end
        end
        last_acc = cyc;
        model_accept(ap, af, dp);
        if (gap) begin
            s_valid = 1'b0;
            s_ap = 16'($urandom); s_af = 16'($urandom); s_dp = 16'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int unsigned w = 0;
        while (exp_q.size() != 0 && w < 40) begin
            @(posedge clk);
            w++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_s_ready"},     s_ready,     0);
        check({pfx, "_bram_en"},     bram_en,     0);
        check({pfx, "_bram_we"},     bram_we,     0);
        check({pfx, "_bram_addr"},   bram_addr,   0);
        check({pfx, "_bram_din"},    bram_din,    0);
        check({pfx, "_frame_done"},  frame_done,  0);
        check({pfx, "_frame_count"}, frame_count, 0);
    endtask

    logic [15:0] c1_ap[4];
    logic [15:0] c1_af[4];
    logic [15:0] c1_dp[4];
    logic [15:0] c2_af[4];
    logic [15:0] c2_dp[4];
    bit          done16 = 0;

    // ---------------- LOG2_N=16 saturation run ----------------
    initial begin
        int unsigned k = 0;
        int unsigned w = 0;
        logic [31:0] exp16[3];
        exp16[0] = 32'd32767; exp16[1] = 32'd32767; exp16[2] = 32'd1;
        rst16_n = 1'b0; v16 = 1'b0;
        ap16 = 16'h8000; af16 = 16'h7fff; dp16 = 16'hffff;
        repeat (3) @(posedge clk);
        #1;
        rst16_n = 1'b1;
        v16 = 1'b1;
        while (k < 3 && w < 70000) begin
            @(negedge clk);
            w++;
            if (en16) begin
                check("n16_addr", addr16, 32'd100 + k);
                check("n16_din", din16, exp16[k]);
                if (k == 2) begin
                    check("n16_frame_done", fd16, 1);
                    check("n16_frame_count", fc16, 1);
                end
                k++;
            end
        end
        if (k < 3) check("n16_write_timeout", k, 3);
        v16 = 1'b0;
        done16 = 1;
    end

    // ---------------- main sequence ----------------
    initial begin
        int unsigned w = 0;
        c1_ap = '{16'd100, 16'hff9c, 16'd60, 16'hffc4};  // 100,-100,60,-60
        c1_af = '{16'd200, 16'd200, 16'd200, 16'd200};
        c1_dp = '{16'hfff8, 16'hfff8, 16'hfff8, 16'hfff8}; // -8 x4
        c2_af = '{16'd5, 16'hfff9, 16'd9, 16'h7fff};
        c2_dp = '{16'd0, 16'd1, 16'hffff, 16'h8000};

        rst_n = 1'b0; s_valid = 1'b0;
        s_ap = 16'd0; s_af = 16'd0; s_dp = 16'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", s_ready, 1);

        // frame 1: basic averages, back-to-back -> addr 0,1,2 = 80,200,8
        for (int i = 0; i < 4; i++) send(c1_ap[i], c1_af[i], c1_dp[i], 0);
        s_valid = 1'b0;
        drain();

        // frame 2: saturation with valid held high -> addr 3,4,5
        for (int i = 0; i < 4; i++) send(16'h8000, c2_af[i], c2_dp[i], 0);
        s_valid = 1'b0;
        drain();

        // frame 3: frame 1 data with valid gaps -> ring wraps to addr 0,1,2
        for (int i = 0; i < 4; i++) send(c1_ap[i], c1_af[i], c1_dp[i], 1);
        drain();

        // frames 4..6: random data, valid held high across the write states
        for (int i = 0; i < 12; i++)
            send(16'($urandom), 16'($urandom), 16'($urandom), 0);
        s_valid = 1'b0;
        drain();

        // reset after 2 of 4 samples: nothing written, model restarts
        send(16'd1000, 16'd2000, 16'd3000, 0);
        send(16'd1000, 16'd2000, 16'd3000, 0);
        s_valid = 1'b0;
        check("pending_before_rst", exp_q.size(), 0);
        rst_n = 1'b0;
        exp_ready_next = 0;
        model_reset();
        #1;
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(c1_ap[i], c1_af[i], c1_dp[i], 1);
        drain();

        while (!done16 && w < 80000) begin
            @(posedge clk);
            w++;
        end
        check("n16_finished", done16, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
